// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the yAlu sharing controller: op codes, FSM encoding
// and the legal-op predicate.
package alu_ctrl_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic is_legal_op(input logic [2:0] op);
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT: return 1'b1;
            default:                               return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: a contested grant goes to the requester that
// did not win last time.
module rr_arb2 (
    input  logic valid0,
    input  logic valid1,
    input  logic last_grant,
    output logic grant,
    output logic grant_valid
);

    always_comb begin
        grant_valid = valid0 | valid1;
        if (valid0 && valid1)
            grant = ~last_grant;
        else
            grant = valid1;
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one combinational yAlu between two requesters: round-robin accept,
// hold operands EXEC_CYCLES cycles, capture and return a tagged response.
// Optional macro ALU_OP_CHECK_EN: illegal ops skip the ALU and return rsp_err.
module alu_share_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int EXEC_CYCLES = 1    // 1..15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [2:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req1_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] alu_z,
    input  logic             alu_ex,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_z,
    output logic             rsp_ex,
    output logic             rsp_err
);

    localparam logic [3:0] CNT_LOAD = 4'(EXEC_CYCLES - 1);

    state_t           state, state_nxt;
    logic             last_grant;
    logic             grant, grant_valid;
    logic             xfer, op_ok;
    logic [3:0]       cnt;
    logic [WIDTH-1:0] sel_a, sel_b;
    logic [2:0]       sel_op;

    rr_arb2 u_arb (
        .valid0      (req0_valid),
        .valid1      (req1_valid),
        .last_grant  (last_grant),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    assign req0_ready = (state == IDLE) && grant_valid && !grant;
    assign req1_ready = (state == IDLE) && grant_valid &&  grant;
    assign xfer       = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    assign sel_a      = grant ? req1_a  : req0_a;
    assign sel_b      = grant ? req1_b  : req0_b;
    assign sel_op     = grant ? req1_op : req0_op;
    assign rsp_valid  = (state == RESP);

`ifdef ALU_OP_CHECK_EN
    logic err_q;

    assign op_ok   = is_legal_op(sel_op);
    assign rsp_err = err_q;

    always_ff @(posedge clk) begin
        if (reset)
            err_q <= 1'b0;
        else if (state == IDLE && xfer)
            err_q <= !op_ok;
    end
`else
    assign op_ok   = 1'b1;
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        // NOTE: default first, so every path assigns state_nxt and no latch is inferred.
        state_nxt = state;
        case (state)
            IDLE:    if (xfer) state_nxt = op_ok ? EXEC : RESP;
            EXEC:    if (cnt == 4'd0) state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath registers; alu_* deliberately keep their values outside EXEC.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            last_grant <= 1'b1;
            cnt        <= 4'd0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= OP_AND;
            rsp_id     <= 1'b0;
            rsp_z      <= '0;
            rsp_ex     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (xfer) begin
                    last_grant <= grant;
                    rsp_id     <= grant;
                    cnt        <= CNT_LOAD;
                    if (op_ok) begin
                        alu_a  <= sel_a;
                        alu_b  <= sel_b;
                        alu_op <= sel_op;
                    end else begin
                        rsp_z  <= '0;
                        rsp_ex <= 1'b0;
                    end
                end
                EXEC: begin
                    if (cnt == 4'd0) begin
                        rsp_z  <= alu_z;
                        rsp_ex <= alu_ex;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Randomised bench: two controllers (EXEC_CYCLES 1 and 4) against a
// transaction-level timing/arbitration model and a behavioural yAlu.
module tb_alu_share_ctrl;

    localparam int W    = 32;
    localparam int NCYC = 4000;

`ifdef ALU_OP_CHECK_EN
    localparam bit OPCHK = 1'b1;
`else
    localparam bit OPCHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic         req_valid [2][2];
    logic         req_ready [2][2];
    logic [W-1:0] req_a     [2][2];
    logic [W-1:0] req_b     [2][2];
    logic [2:0]   req_op    [2][2];
    logic [W-1:0] alu_a [2], alu_b [2], alu_z [2];
    logic [2:0]   alu_op [2];
    logic         alu_ex [2];
    logic         rsp_valid [2], rsp_ready [2], rsp_id [2], rsp_ex [2], rsp_err [2];
    logic [W-1:0] rsp_z [2];

    // Behavioural external yAlu; ex flags signed overflow on ADD/SUB.
    function automatic logic [W:0] yalu(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic [2:0] op);
        logic [W-1:0] z;
        logic         ex;
        ex = 1'b0;
        case (op)
            3'b000: z = a & b;
            3'b001: z = a | b;
            3'b010: begin z = a + b; ex = (a[W-1] == b[W-1]) && (z[W-1] != a[W-1]); end
            3'b110: begin z = a - b; ex = (a[W-1] != b[W-1]) && (z[W-1] != a[W-1]); end
            3'b111: z = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
            default: z = a ^ b;
        endcase
        return {ex, z};
    endfunction

    assign {alu_ex[0], alu_z[0]} = yalu(alu_a[0], alu_b[0], alu_op[0]);
    assign {alu_ex[1], alu_z[1]} = yalu(alu_a[1], alu_b[1], alu_op[1]);

    alu_share_ctrl #(.WIDTH(W), .EXEC_CYCLES(1)) dut_e1 (
        .clk(clk), .reset(reset),
        .req0_valid(req_valid[0][0]), .req0_ready(req_ready[0][0]),
        .req0_a(req_a[0][0]), .req0_b(req_b[0][0]), .req0_op(req_op[0][0]),
        .req1_valid(req_valid[0][1]), .req1_ready(req_ready[0][1]),
        .req1_a(req_a[0][1]), .req1_b(req_b[0][1]), .req1_op(req_op[0][1]),
        .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_op(alu_op[0]),
        .alu_z(alu_z[0]), .alu_ex(alu_ex[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_id(rsp_id[0]),
        .rsp_z(rsp_z[0]), .rsp_ex(rsp_ex[0]), .rsp_err(rsp_err[0])
    );

    alu_share_ctrl #(.WIDTH(W), .EXEC_CYCLES(4)) dut_e4 (
        .clk(clk), .reset(reset),
        .req0_valid(req_valid[1][0]), .req0_ready(req_ready[1][0]),
        .req0_a(req_a[1][0]), .req0_b(req_b[1][0]), .req0_op(req_op[1][0]),
        .req1_valid(req_valid[1][1]), .req1_ready(req_ready[1][1]),
        .req1_a(req_a[1][1]), .req1_b(req_b[1][1]), .req1_op(req_op[1][1]),
        .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_op(alu_op[1]),
        .alu_z(alu_z[1]), .alu_ex(alu_ex[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_id(rsp_id[1]),
        .rsp_z(rsp_z[1]), .rsp_ex(rsp_ex[1]), .rsp_err(rsp_err[1])
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference model: one outstanding transaction per controller, described
    // by the cycle at which its response must become visible.
    logic         m_busy [2], m_last [2], m_id [2], m_ex [2], m_err [2], m_post_rst [2];
    int           m_rsp_from [2];
    logic [W-1:0] m_z [2], m_alu_a [2], m_alu_b [2];
    logic [2:0]   m_alu_op [2];
    logic         pend [2][2];
    int           stall_left [2];
    logic [2:0]   legal_ops [5] = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111};
    logic [2:0]   bad_ops   [3] = '{3'b011, 3'b100, 3'b101};

    function automatic int exec_of(input int k);
        return (k == 0) ? 1 : 4;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_busy[k] = 1'b0;   m_last[k] = 1'b1;   m_id[k] = 1'b0;
            m_z[k] = '0;        m_ex[k] = 1'b0;     m_err[k] = 1'b0;
            m_alu_a[k] = '0;    m_alu_b[k] = '0;    m_alu_op[k] = 3'b000;
            m_post_rst[k] = 1'b1;
        end
    endtask

    function automatic logic [W-1:0] rand_operand();
        if ($urandom_range(0, 1) == 0) return W'($signed($urandom_range(0, 16)) - 8);
        return W'($urandom);
    endfunction

    initial begin
        logic         gen, rst_now, e_r0, e_r1, e_valid, has_w, w;
        logic [W-1:0] a, b;
        logic [2:0]   op;
        string        p;

        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            rsp_ready[k] = 1'b0;
            stall_left[k] = 0;
            for (int n = 0; n < 2; n++) begin
                req_valid[k][n] = 1'b0; req_a[k][n] = '0; req_b[k][n] = '0;
                req_op[k][n] = 3'b000;  pend[k][n] = 1'b0;
            end
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            p = $sformatf("rst dut%0d", k);
            check({p, " req0_ready"}, W'(req_ready[k][0]), '0);
            check({p, " req1_ready"}, W'(req_ready[k][1]), '0);
            check({p, " rsp_valid"},  W'(rsp_valid[k]), '0);
            check({p, " alu_a"},      alu_a[k], '0);
            check({p, " alu_op"},     W'(alu_op[k]), '0);
        end
        model_reset();

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            rst_now = (cyc >= 60) && ($urandom_range(0, 299) == 0);
            reset = rst_now;
            for (int k = 0; k < 2; k++) begin
                for (int n = 0; n < 2; n++) begin
                    gen = 1'b0; a = '0; b = '0; op = 3'b000;
                    if (!pend[k][n]) begin
                        if (cyc < 4) begin
                            if (cyc == 0 && n == 0) begin gen = 1'b1; a = 5; b = 3; op = 3'b010; end
                        end else if (cyc < 40) begin
                            gen = 1'b1;
                            if (n == 0) begin a = 6; b = 9; op = 3'b110; end
                            else        begin a = '1; b = 1; op = 3'b111; end
                        end else if (cyc < 60) begin
                            if (n == 1) begin gen = 1'b1; a = 32'hF0; b = 32'h0F; op = 3'b001; end
                        end else if ($urandom_range(0, 99) < 40) begin
                            gen = 1'b1; a = rand_operand(); b = rand_operand();
                            if ($urandom_range(0, 19) < 17) op = legal_ops[$urandom_range(0, 4)];
                            else                            op = bad_ops[$urandom_range(0, 2)];
                        end
                    end
                    if (gen) begin
                        req_a[k][n] = a; req_b[k][n] = b; req_op[k][n] = op; pend[k][n] = 1'b1;
                    end
                    req_valid[k][n] = pend[k][n];
                end
                if (cyc < 41)      rsp_ready[k] = 1'b1;
                else if (cyc < 52) rsp_ready[k] = 1'b0;
                else if (stall_left[k] > 0) begin
                    rsp_ready[k] = 1'b0; stall_left[k]--;
                end else if ($urandom_range(0, 99) < 3) begin
                    rsp_ready[k] = 1'b0; stall_left[k] = 10 + $urandom_range(0, 10);
                end else
                    rsp_ready[k] = ($urandom_range(0, 99) < 70);
            end
            #1;
            for (int k = 0; k < 2; k++) begin
                p = $sformatf("dut%0d c%0d", k, cyc);
                has_w = 1'b0; w = 1'b0;
                if (!m_busy[k]) begin
                    if (pend[k][0] && pend[k][1]) begin has_w = 1'b1; w = ~m_last[k]; end
                    else if (pend[k][1])          begin has_w = 1'b1; w = 1'b1; end
                    else if (pend[k][0])          begin has_w = 1'b1; w = 1'b0; end
                end
                e_r0 = has_w && !w;
                e_r1 = has_w && w;
                e_valid = m_busy[k] && (cyc >= m_rsp_from[k]);
                check({p, " req0_ready"}, W'(req_ready[k][0]), W'(e_r0));
                check({p, " req1_ready"}, W'(req_ready[k][1]), W'(e_r1));
                check({p, " rsp_valid"},  W'(rsp_valid[k]), W'(e_valid));
                check({p, " alu_a"},      alu_a[k], m_alu_a[k]);
                check({p, " alu_b"},      alu_b[k], m_alu_b[k]);
                check({p, " alu_op"},     W'(alu_op[k]), W'(m_alu_op[k]));
                if (e_valid || m_post_rst[k]) begin
                    check({p, " rsp_id"},  W'(rsp_id[k]), W'(m_id[k]));
                    check({p, " rsp_z"},   rsp_z[k], m_z[k]);
                    check({p, " rsp_ex"},  W'(rsp_ex[k]), W'(m_ex[k]));
                    check({p, " rsp_err"}, W'(rsp_err[k]), W'(m_err[k]));
                end
                m_post_rst[k] = 1'b0;

                if (rst_now) begin
                    // handled after the loop
                end else if (e_valid && rsp_ready[k]) begin
                    m_busy[k] = 1'b0;
                end else if (has_w) begin
                    a = req_a[k][w]; b = req_b[k][w]; op = req_op[k][w];
                    pend[k][w] = 1'b0;
                    m_busy[k] = 1'b1; m_last[k] = w; m_id[k] = w;
                    if (OPCHK && !(op inside {3'b000, 3'b001, 3'b010, 3'b110, 3'b111})) begin
                        m_rsp_from[k] = cyc + 1;
                        m_z[k] = '0; m_ex[k] = 1'b0; m_err[k] = 1'b1;
                    end else begin
                        m_rsp_from[k] = cyc + exec_of(k) + 1;
                        {m_ex[k], m_z[k]} = yalu(a, b, op);
                        m_err[k] = 1'b0;
                        m_alu_a[k] = a; m_alu_b[k] = b; m_alu_op[k] = op;
                    end
                end
            end
            if (rst_now) model_reset();
            @(posedge clk);
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_share_ctrl.md
Name: alu_share_ctrl

Overview:
- Sequencer and arbiter that shares one external combinational yAlu between two requesters (e.g. the execute stage and the branch-compare path).
- Arbitrates round-robin and registers the chosen operands onto the ALU inputs.
- Waits a programmable settle time, captures z/ex, and returns a tagged response over a valid/ready handshake.
- Sits between the requesters and the single yAlu instance in the CPU datapath.

Parameters:
- WIDTH, 32, operand/result width.
- EXEC_CYCLES, 1, clock cycles the ALU inputs are held stable before capture; legal range 1..15.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- reqN_valid  in  1  requester N (N=0,1) has an operation pending.
- reqN_ready  out  1  controller accepts requester N this cycle.
- reqN_a  in  WIDTH  operand a, signed.
- reqN_b  in  WIDTH  operand b, signed.
- reqN_op  in  3  ALU op: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.
- alu_a  out  WIDTH  registered operand to yAlu.
- alu_b  out  WIDTH  registered operand to yAlu.
- alu_op  out  3  registered op to yAlu.
- alu_z  in  WIDTH  yAlu result.
- alu_ex  in  1  yAlu ex flag.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer takes the response.
- rsp_id  out  1  requester index the response belongs to.
- rsp_z  out  WIDTH  captured result.
- rsp_ex  out  1  captured ex flag.
- rsp_err  out  1  illegal-op flag; only meaningful with the optional feature.

Behaviour:
- Reset (clk and reset are synchronous, reset active-high):
  - state=IDLE; last_grant=1, so req0 wins the first tie.
  - All outputs 0: alu_a, alu_b, alu_op=000, rsp_* and reqN_ready.
  - Counter=0.
- reqN_ready is combinational: asserted only when state==IDLE and grant==N. Never asserted for both requesters in the same cycle. A transfer occurs when valid&&ready.
- Grant in IDLE:
  - Only one requester valid: that one.
  - Both valid: the one not equal to last_grant.
  - last_grant updates on transfer.
- IDLE -> EXEC on transfer:
  - Register a/b/op into alu_a/alu_b/alu_op.
  - Register the requester index into rsp_id.
  - Load counter = EXEC_CYCLES-1.
- EXEC:
  - alu_* held stable; counter decrements each cycle.
  - When counter==0: capture alu_z->rsp_z and alu_ex->rsp_ex, go to RESP.
- RESP:
  - rsp_valid=1; rsp_id/z/ex/err held stable until rsp_ready.
  - On rsp_valid&&rsp_ready: rsp_valid drops next cycle, state -> IDLE.
  - No new request is accepted in the cycle the response is taken.
- Latency: accept at edge T; rsp_valid high from T+EXEC_CYCLES+1. Max throughput is one op per EXEC_CYCLES+2 cycles.
- alu_* keep their last values in IDLE/RESP; they are not cleared.
- reqN inputs are ignored when not ready. The requester must hold a/b/op stable while valid is high and it is not yet accepted.
- rsp_ready held low: the controller stalls in RESP indefinitely. Both requesters see ready=0.
- Reset asserted in any state: the in-flight transaction is discarded; next cycle is the reset state. No response is produced.
- Result arithmetic is entirely the yAlu's. The controller passes all WIDTH bits unchanged; no sign handling here.
- Without the optional feature: rsp_err is constant 0.

Optional Feature:
- Macro: ALU_OP_CHECK_EN.
- Defined:
  - On transfer, an op not in {000,001,010,110,111} bypasses EXEC: state -> RESP next cycle.
  - rsp_z=0, rsp_ex=0, rsp_err=1; alu_* are not updated.
  - Legal ops give rsp_err=0.
- Undefined: every op is sent to the ALU unchanged; rsp_err tied 0.

Decomposition:
- Package alu_ctrl_pkg:
  - Op constants OP_AND=3'b000, OP_OR=3'b001, OP_ADD=3'b010, OP_SUB=3'b110, OP_SLT=3'b111.
  - State encoding IDLE=2'd0, EXEC=2'd1, RESP=2'd2.
  - Function is_legal_op.
- Sub-module rr_arb2:
  - Inputs: two valids, last_grant.
  - Outputs: grant index and grant_valid.
  - Purely combinational; instantiated once.

Test Plan:
- Reset then req0 a=5 b=3 op=010, EXEC_CYCLES=1, rsp_ready=1 -> req0_ready at T; rsp_valid at T+2 with rsp_id=0, rsp_z=8.
- Both valid every cycle: req0 SUB a=6 b=9, req1 SLT a=-1 b=1 -> responses alternate id 0,1,0,1; z=32'hFFFFFFFD and 1 respectively.
- rsp_ready held 0 for 10 cycles with req1 valid -> rsp_valid/z stable, req1_ready=0 throughout; rsp_ready=1 -> req1 accepted 1 cycle after rsp taken.
- EXEC_CYCLES=4, req1 OR a=32'hF0 b=32'h0F -> alu_* stable 4 cycles; rsp_valid at T+5 with z=32'hFF.
- Reset pulsed during EXEC -> no rsp_valid; all outputs 0 next cycle; req0 wins the next tie.
- With ALU_OP_CHECK_EN, op=011 -> rsp_valid at T+1, rsp_err=1, rsp_z=0, alu_op unchanged; without the macro, rsp_err stays 0 and alu_op=011 is driven.
